// File: rtl/ov5640_pkg.sv
// ----------------------------------------------------------------------------
// ov5640_pkg
// Shared types and constants for the OV5640 DVP capture path.
//   cap_state_e        : capture FSM states (WAIT_CFG, SKIP, CAPTURE)
//   PIX_W              : RGB565 pixel width
//   DVP_W              : bundled DVP width {pclk, vsync, href, data[7:0]}
//   DEFAULT_FRAME_SKIP : settling frames discarded after configuration
//   FRAME_CNT_W/LINE_CNT_W : statistics counter widths
// ----------------------------------------------------------------------------
package ov5640_pkg;

    typedef enum logic [1:0] {
        WAIT_CFG = 2'd0,
        SKIP     = 2'd1,
        CAPTURE  = 2'd2
    } cap_state_e;

    localparam int PIX_W              = 16;
    localparam int DVP_W              = 11;
    localparam int DEFAULT_FRAME_SKIP = 10;
    localparam int FRAME_CNT_W        = 16;
    localparam int LINE_CNT_W         = 12;

    // The sensor sends the high byte of each RGB565 pixel first.
    function automatic logic [PIX_W-1:0] rgb565_pack(input logic [7:0] hi, input logic [7:0] lo);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/dvp_sync.sv
// ----------------------------------------------------------------------------
// dvp_sync
// Brings the DVP bus into the sclk domain. Every signal goes through a
// 2-flop synchronizer; pclk additionally gets a history flop so its rising
// edge can be detected. The edge pulse and the aligned vsync/href/data
// sample are registered together.
//   sclk, s_rst_n               : system clock, async active-low reset
//   cam_pclk/vsync/href/data    : raw DVP inputs (pclk treated as data)
//   pclk_rise                   : one-sclk pulse per detected pclk rise
//   smp_vsync/smp_href/smp_data : sample aligned with pclk_rise
// ----------------------------------------------------------------------------
module dvp_sync
    import ov5640_pkg::*;
(
    input  logic       sclk,
    input  logic       s_rst_n,
    input  logic       cam_pclk,
    input  logic       cam_vsync,
    input  logic       cam_href,
    input  logic [7:0] cam_data,
    output logic       pclk_rise,
    output logic       smp_vsync,
    output logic       smp_href,
    output logic [7:0] smp_data
);

    logic [DVP_W-1:0] sync1, sync2;
    logic             pclk_hist;

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            sync1     <= '0;
            sync2     <= '0;
            pclk_hist <= 1'b0;
            pclk_rise <= 1'b0;
            smp_vsync <= 1'b0;
            smp_href  <= 1'b0;
            smp_data  <= '0;
        end else begin
            sync1     <= {cam_pclk, cam_vsync, cam_href, cam_data};
            sync2     <= sync1;
            pclk_hist <= sync2[DVP_W-1];
            // Data was launched on the preceding pclk fall, so it is already
            // settled in sync2 when the pclk rise reaches the same stage.
            pclk_rise <= sync2[DVP_W-1] & ~pclk_hist;
            {smp_vsync, smp_href, smp_data} <= sync2[DVP_W-2:0];
        end
    end

endmodule

// File: rtl/ov5640_capture.sv
// ----------------------------------------------------------------------------
// ov5640_capture
// Waits for cfg_done, drops FRAME_SKIP settling frames, then packs DVP byte
// pairs into RGB565 pixels with start-of-frame / end-of-line markers. The
// sensor is never stalled: a pixel emitted while pix_ready=0 sets sticky ovf.
//   sclk, s_rst_n      : system clock (>= 3x pclk), async active-low reset
//   cfg_done           : sensor configured (level, sclk domain)
//   cam_*              : DVP bus, asynchronous
//   pix_ready          : downstream accept
//   pix_valid/data/sof/eol : pixel output, one-cycle pulse, registered
//   ovf                : sticky drop flag, cleared on a vsync rise in CAPTURE
//   capturing          : FSM in CAPTURE
// Optional: OV5640_CAP_STATS_EN adds frame_cnt / line_cnt outputs.
// ----------------------------------------------------------------------------
module ov5640_capture
    import ov5640_pkg::*;
#(
    parameter int H_PIXELS   = 640,
    parameter int FRAME_SKIP = DEFAULT_FRAME_SKIP
) (
    input  logic             sclk,
    input  logic             s_rst_n,
    input  logic             cfg_done,
    input  logic             cam_pclk,
    input  logic             cam_vsync,
    input  logic             cam_href,
    input  logic [7:0]       cam_data,
    input  logic             pix_ready,
    output logic             pix_valid,
    output logic [PIX_W-1:0] pix_data,
    output logic             pix_sof,
    output logic             pix_eol,
    output logic             ovf,
    output logic             capturing
`ifdef OV5640_CAP_STATS_EN
    ,
    output logic [FRAME_CNT_W-1:0] frame_cnt,
    output logic [LINE_CNT_W-1:0]  line_cnt
`endif
);

    localparam int XW     = $clog2(H_PIXELS + 1);
    localparam int SKIP_W = $clog2(FRAME_SKIP + 2);
    localparam logic [XW-1:0]     X_LAST    = XW'(H_PIXELS - 1);
    localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'(FRAME_SKIP);

    cap_state_e        state;
    logic              rise, smp_vs, smp_hs;
    logic [7:0]        smp_d;
    logic              prev_vs;
    logic              vs_rise, enter_cap;
    logic              phase, sof_pend;
    logic [7:0]        hi_byte;
    logic [XW-1:0]     x_cnt;
    logic [SKIP_W-1:0] skip_cnt;

    dvp_sync u_sync (
        .sclk      (sclk),
        .s_rst_n   (s_rst_n),
        .cam_pclk  (cam_pclk),
        .cam_vsync (cam_vsync),
        .cam_href  (cam_href),
        .cam_data  (cam_data),
        .pclk_rise (rise),
        .smp_vsync (smp_vs),
        .smp_href  (smp_hs),
        .smp_data  (smp_d)
    );

    assign vs_rise   = rise & smp_vs & ~prev_vs;
    assign enter_cap = (state == SKIP) & vs_rise & (skip_cnt == SKIP_LAST);
    assign capturing = (state == CAPTURE);

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state     <= WAIT_CFG;
            prev_vs   <= 1'b0;
            phase     <= 1'b0;
            sof_pend  <= 1'b0;
            hi_byte   <= '0;
            x_cnt     <= '0;
            skip_cnt  <= '0;
            pix_valid <= 1'b0;
            pix_data  <= '0;
            pix_sof   <= 1'b0;
            pix_eol   <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            pix_valid <= 1'b0;
            if (rise) prev_vs <= smp_vs;

            if (!cfg_done) begin
                state    <= WAIT_CFG;
                phase    <= 1'b0;
                x_cnt    <= '0;
                skip_cnt <= '0;
                sof_pend <= 1'b0;
            end else begin
                case (state)
                    WAIT_CFG: begin
                        state    <= SKIP;
                        skip_cnt <= '0;
                    end
                    SKIP: begin
                        if (enter_cap) begin
                            state    <= CAPTURE;
                            sof_pend <= 1'b1;
                            phase    <= 1'b0;
                            x_cnt    <= '0;
                        end else if (vs_rise) begin
                            skip_cnt <= skip_cnt + 1'b1;
                        end
                    end
                    CAPTURE: begin
                        if (rise) begin
                            if (smp_hs) begin
                                if (!phase) begin
                                    hi_byte <= smp_d;
                                    phase   <= 1'b1;
                                end else begin
                                    pix_valid <= 1'b1;
                                    pix_data  <= rgb565_pack(hi_byte, smp_d);
                                    pix_sof   <= sof_pend;
                                    pix_eol   <= (x_cnt == X_LAST);
                                    sof_pend  <= 1'b0;
                                    phase     <= 1'b0;
                                    if (x_cnt != X_LAST) x_cnt <= x_cnt + 1'b1;
                                end
                            end else begin
                                // Line gap: a dangling high byte is dropped here.
                                phase <= 1'b0;
                                x_cnt <= '0;
                            end
                            if (vs_rise) sof_pend <= 1'b1;
                        end
                    end
                    default: state <= WAIT_CFG;
                endcase
            end

            // A drop in the same cycle as the frame boundary keeps the flag set.
            if (pix_valid && !pix_ready)       ovf <= 1'b1;
            else if (capturing && vs_rise)     ovf <= 1'b0;
        end
    end

`ifdef OV5640_CAP_STATS_EN
    logic prev_hs;
    logic href_fall;

    assign href_fall = rise & ~smp_hs & prev_hs;

    // The vsync rise that enters CAPTURE opens the first captured frame,
    // so it is counted along with the rises seen while capturing.
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            prev_hs   <= 1'b0;
            frame_cnt <= '0;
            line_cnt  <= '0;
        end else begin
            if (rise) prev_hs <= smp_hs;
            if (!cfg_done) begin
                frame_cnt <= '0;
                line_cnt  <= '0;
            end else begin
                if (enter_cap || (capturing && vs_rise)) frame_cnt <= frame_cnt + 1'b1;
                if (vs_rise)
                    line_cnt <= '0;
                else if (capturing && href_fall && line_cnt != '1)
                    line_cnt <= line_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ov5640_capture.sv
// ----------------------------------------------------------------------------
// tb_ov5640_capture
// Drives DVP frames with a 40 ns pclk against a 10 ns sclk. Expected pixels
// are queued as the second byte of each pair is driven and are popped by a
// monitor when pix_valid pulses. Built with H_PIXELS=4, FRAME_SKIP=2.
// ----------------------------------------------------------------------------
module tb_ov5640_capture;
    import ov5640_pkg::*;

    localparam int H = 4;
    localparam int FS = 2;

    typedef struct packed {
        logic [15:0] d;
        logic        sof;
        logic        eol;
    } exp_t;

    logic        sclk = 1'b0;
    logic        s_rst_n, cfg_done, cam_pclk, cam_vsync, cam_href, pix_ready;
    logic [7:0]  cam_data;
    logic        pix_valid, pix_sof, pix_eol, ovf, capturing;
    logic [15:0] pix_data;
`ifdef OV5640_CAP_STATS_EN
    logic [FRAME_CNT_W-1:0] frame_cnt;
    logic [LINE_CNT_W-1:0]  line_cnt;
`endif

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_pix    = 0;

    always #5 sclk = ~sclk;

    ov5640_capture #(.H_PIXELS(H), .FRAME_SKIP(FS)) dut (
        .sclk      (sclk),
        .s_rst_n   (s_rst_n),
        .cfg_done  (cfg_done),
        .cam_pclk  (cam_pclk),
        .cam_vsync (cam_vsync),
        .cam_href  (cam_href),
        .cam_data  (cam_data),
        .pix_ready (pix_ready),
        .pix_valid (pix_valid),
        .pix_data  (pix_data),
        .pix_sof   (pix_sof),
        .pix_eol   (pix_eol),
        .ovf       (ovf),
        .capturing (capturing)
`ifdef OV5640_CAP_STATS_EN
        ,
        .frame_cnt (frame_cnt),
        .line_cnt  (line_cnt)
`endif
    );

    // Scoreboard consumer.
    always @(negedge sclk) begin
        if (s_rst_n && pix_valid) begin
            exp_t e;
            n_checks++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_pix: got data=%h sof=%b eol=%b, none expected",
                         pix_data, pix_sof, pix_eol);
            end else begin
                e = sb.pop_front();
                n_pix++;
                if ({pix_data, pix_sof, pix_eol} !== {e.d, e.sof, e.eol})
                    $display("FAIL pixel: got data=%h sof=%b eol=%b, want data=%h sof=%b eol=%b",
                             pix_data, pix_sof, pix_eol, e.d, e.sof, e.eol);
                else
                    n_pass++;
            end
        end
    end

    task automatic send_byte(input logic vs, input logic hs, input logic [7:0] d);
        cam_vsync = vs;
        cam_href  = hs;
        cam_data  = d;
        #20 cam_pclk = 1'b1;
        #20 cam_pclk = 1'b0;
    endtask

    task automatic send_vsync();
        for (int i = 0; i < 3; i++) send_byte(1'b1, 1'b0, 8'hEE);
        for (int i = 0; i < 2; i++) send_byte(1'b0, 1'b0, 8'h00);
    endtask

    // Byte values run 1..nbytes; pixel k is {2k+1, 2k+2}.
    task automatic send_line(input int nbytes, input bit exp, input bit sof, input bit tail);
        for (int i = 0; i < nbytes; i++) begin
            if (exp && (i % 2 == 1)) begin
                exp_t e;
                e.d   = {8'(i), 8'(i + 1)};
                e.sof = sof && (i == 1);
                e.eol = ((i / 2) >= H - 1);
                sb.push_back(e);
            end
            send_byte(1'b0, 1'b1, 8'(i + 1));
        end
        if (tail) for (int i = 0; i < 2; i++) send_byte(1'b0, 1'b0, 8'h00);
    endtask

    task automatic send_frame(input int lines, input int nbytes, input bit exp);
        send_vsync();
        for (int l = 0; l < lines; l++) send_line(nbytes, exp, exp && (l == 0), 1'b1);
    endtask

    task automatic check_drained(input string name);
        #100;
        n_checks++;
        if (sb.size() != 0) $display("FAIL %s: %0d pixels never produced, want 0", name, sb.size());
        else n_pass++;
    endtask

    task automatic check_capturing(input string name, input logic want);
        n_checks++;
        if (capturing !== want) $display("FAIL %s: capturing=%b want %b", name, capturing, want);
        else n_pass++;
    endtask

    task automatic test_reset();
        n_checks++;
        if ({pix_valid, pix_data, pix_sof, pix_eol, ovf, capturing} !== 21'd0)
            $display("FAIL reset_outputs: valid=%b data=%h sof=%b eol=%b ovf=%b cap=%b, want all 0",
                     pix_valid, pix_data, pix_sof, pix_eol, ovf, capturing);
        else n_pass++;
        n_checks++;
        if (dut.state !== WAIT_CFG) $display("FAIL reset_state: state=%0d want %0d", dut.state, WAIT_CFG);
        else n_pass++;
    endtask

    task automatic test_no_cfg();
        for (int f = 0; f < 3; f++) send_frame(2, 2 * H, 1'b0);
        check_capturing("no_cfg_capturing", 1'b0);
        check_drained("no_cfg_drain");
    endtask

    task automatic test_skip();
        int p0;
        cfg_done = 1'b1;
        #40;
        p0 = n_pix;
        send_frame(2, 2 * H, 1'b0);
        send_frame(2, 2 * H, 1'b0);
        check_capturing("skip_still_skipping", 1'b0);
        send_frame(2, 2 * H, 1'b1);
        send_frame(2, 2 * H, 1'b1);
        check_capturing("skip_capturing", 1'b1);
        check_drained("skip_drain");
        n_checks++;
        if (n_pix - p0 != 16) $display("FAIL skip_pixel_count: got %0d want 16", n_pix - p0);
        else n_pass++;
    endtask

    task automatic test_odd_line();
        send_vsync();
        send_line(7, 1'b1, 1'b1, 1'b1);
        send_line(2 * H, 1'b1, 1'b0, 1'b1);
        check_drained("odd_line_drain");
    endtask

    task automatic test_ovf();
        send_vsync();
        pix_ready = 1'b0;
        send_line(2, 1'b1, 1'b1, 1'b1);
        pix_ready = 1'b1;
        n_checks++;
        if (ovf !== 1'b1) $display("FAIL ovf_set: ovf=%b want 1", ovf);
        else n_pass++;
        send_line(2 * H, 1'b1, 1'b0, 1'b1);
        n_checks++;
        if (ovf !== 1'b1) $display("FAIL ovf_sticky: ovf=%b want 1", ovf);
        else n_pass++;
        send_vsync();
        n_checks++;
        if (ovf !== 1'b0) $display("FAIL ovf_clear: ovf=%b want 0", ovf);
        else n_pass++;
        check_drained("ovf_drain");
    endtask

    task automatic test_cfg_drop();
        send_vsync();
        send_line(4, 1'b1, 1'b1, 1'b0);
        #60;
        cfg_done = 1'b0;
        #20;
        check_capturing("drop_capturing", 1'b0);
        n_checks++;
        if (dut.state !== WAIT_CFG) $display("FAIL drop_state: state=%0d want %0d", dut.state, WAIT_CFG);
        else n_pass++;
        send_line(4, 1'b0, 1'b0, 1'b1);
        check_drained("drop_drain");
        cfg_done = 1'b1;
        #40;
        send_frame(2, 2 * H, 1'b0);
        send_frame(2, 2 * H, 1'b0);
        check_capturing("recfg_skipping", 1'b0);
        send_frame(2, 2 * H, 1'b1);
        check_capturing("recfg_capturing", 1'b1);
        check_drained("recfg_drain");
    endtask

`ifdef OV5640_CAP_STATS_EN
    task automatic test_stats();
        cfg_done = 1'b0;
        #20;
        n_checks++;
        if (frame_cnt !== '0 || line_cnt !== '0)
            $display("FAIL stats_clear: frame_cnt=%0d line_cnt=%0d want 0/0", frame_cnt, line_cnt);
        else n_pass++;
        cfg_done = 1'b1;
        #40;
        send_frame(1, 2 * H, 1'b0);
        send_frame(1, 2 * H, 1'b0);
        for (int f = 0; f < 3; f++) send_frame(5, 2 * H, 1'b1);
        n_checks++;
        if (frame_cnt !== 16'd3) $display("FAIL stats_frame_cnt: got %0d want 3", frame_cnt);
        else n_pass++;
        n_checks++;
        if (line_cnt !== 12'd5) $display("FAIL stats_line_cnt: got %0d want 5", line_cnt);
        else n_pass++;
        check_drained("stats_drain");
    endtask
`endif

    initial begin
        s_rst_n   = 1'b0;
        cfg_done  = 1'b0;
        cam_pclk  = 1'b0;
        cam_vsync = 1'b0;
        cam_href  = 1'b0;
        cam_data  = 8'h00;
        pix_ready = 1'b1;
        #3;
        test_reset();
        #20 s_rst_n = 1'b1;
        #20;
        test_no_cfg();
        test_skip();
        test_odd_line();
        test_ovf();
        test_cfg_drop();
`ifdef OV5640_CAP_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
